// File: rtl/fir_out_decim_if.sv
// Output handshake bundle of fir_out_decim: FIFO head word toward the next consumer.
interface fir_out_decim_if #(
    parameter int OUT_W = 16
);
    logic [OUT_W-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fir_out_decim.sv
// Block-average decimator (round-half-up) for fir_filter output, followed by a
// first-word-fall-through FIFO with valid/ready drain and a sticky overflow flag.
module fir_out_decim #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 16,
    parameter int DEC_LOG2 = 2,
    parameter int DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic [IN_W-1:0]          y_in,
    input  logic                     y_valid,
    fir_out_decim_if.master          m,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     overflow
);
    localparam int D  = 1 << DEC_LOG2;
    localparam int AW = IN_W + DEC_LOG2;
    localparam int CW = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int FW = PW + 1;
    localparam int R  = (DEC_LOG2 > 0) ? (1 << (DEC_LOG2 - 1)) : 0;

    logic [AW-1:0]    acc;
    logic [CW-1:0]    cnt;
    logic [AW-1:0]    sum;
    logic [IN_W-1:0]  avg;
    logic [OUT_W-1:0] out_word;
    logic             last;
    logic             complete;
    logic             pop;
    logic             push;
    logic             full;

    logic [OUT_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;

    always_comb begin
        last     = (cnt == CW'(D - 1));
        complete = y_valid && last;
        sum      = acc + AW'(y_in) + AW'(R);
        avg      = IN_W'(sum >> DEC_LOG2);
    end

    generate
        if (OUT_W >= IN_W) begin : g_zext
            assign out_word = OUT_W'(avg);
        end else begin : g_sat
            assign out_word = (|avg[IN_W-1:OUT_W]) ? '1 : avg[OUT_W-1:0];
        end
    endgenerate

    // A full FIFO still accepts the new word when the head leaves on the same edge.
    always_comb begin
        full      = (fill == FW'(DEPTH));
        m.m_valid = (fill != '0);
        m.m_data  = m.m_valid ? mem[rp] : '0;
        pop       = m.m_valid && m.m_ready;
        push      = complete && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            acc <= '0;
            cnt <= '0;
        end else if (y_valid) begin
            if (last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= acc + AW'(y_in);
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!res && push) begin
            mem[wp] <= out_word;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            wp       <= '0;
            rp       <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + PW'(1);
            end
            if (pop) begin
                rp <= rp + PW'(1);
            end
            case ({push, pop})
                2'b10:   fill <= fill + FW'(1);
                2'b01:   fill <= fill - FW'(1);
                default: fill <= fill;
            endcase
            if (complete && !push) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fir_out_decim.sv
// Self-checking bench for fir_out_decim: directed scenarios plus randomized traffic,
// compared each cycle against a queue-based behavioural model.
module tb_fir_out_decim;
    localparam int IN_W     = 16;
    localparam int OUT_W    = 16;
    localparam int DEC_LOG2 = 2;
    localparam int DEPTH    = 8;
    localparam int D        = 1 << DEC_LOG2;
    localparam int R        = (DEC_LOG2 > 0) ? (1 << (DEC_LOG2 - 1)) : 0;

    logic                   clk;
    logic                   res;
    logic [IN_W-1:0]        y_in;
    logic                   y_valid;
    logic [$clog2(DEPTH):0] fill;
    logic                   overflow;

    fir_out_decim_if #(.OUT_W(OUT_W)) mif ();

    fir_out_decim #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .DEC_LOG2(DEC_LOG2),
        .DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .res     (res),
        .y_in    (y_in),
        .y_valid (y_valid),
        .m       (mif),
        .fill    (fill),
        .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    // Reference model state: expected FIFO contents and the open block.
    int unsigned q[$];
    longint unsigned blk_sum;
    int unsigned blk_n;
    bit          ref_ovf;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit yv, input int unsigned y, input bit rdy, input bit rst);
        bit          pop;
        bit          done;
        longint unsigned avg;
        if (rst) begin
            q.delete();
            blk_sum = 0;
            blk_n   = 0;
            ref_ovf = 1'b0;
            return;
        end
        pop  = rdy && (q.size() != 0);
        done = 1'b0;
        avg  = 0;
        if (yv) begin
            blk_sum += y;
            blk_n++;
            if (blk_n == D) begin
                avg = (blk_sum + R) / D;
                if (avg > (64'd1 << OUT_W) - 1) avg = (64'd1 << OUT_W) - 1;
                done    = 1'b1;
                blk_sum = 0;
                blk_n   = 0;
            end
        end
        if (pop) void'(q.pop_front());
        if (done) begin
            if (q.size() < DEPTH) q.push_back(int'(avg));
            else ref_ovf = 1'b1;
        end
    endtask

    task automatic step(input bit yv, input int unsigned y, input bit rdy, input bit rst);
        y_valid     = yv;
        y_in        = IN_W'(y);
        mif.m_ready = rdy;
        res         = rst;
        @(posedge clk);
        model_edge(yv, y, rdy, rst);
        #1;
        check("m_valid", mif.m_valid, (q.size() != 0));
        check("m_data", mif.m_data, (q.size() != 0) ? q[0] : 0);
        check("fill", fill, q.size());
        check("overflow", overflow, ref_ovf);
    endtask

    task automatic block(input int unsigned v, input bit rdy);
        for (int i = 0; i < D; i++) step(1'b1, v, rdy, 1'b0);
    endtask

    initial begin
        int unsigned v;
        y_valid     = 1'b0;
        y_in        = '0;
        mif.m_ready = 1'b0;
        res         = 1'b1;
        blk_sum     = 0;
        blk_n       = 0;
        ref_ovf     = 1'b0;

        step(1'b0, 0, 1'b0, 1'b1);
        check("rst_m_valid", mif.m_valid, 0);
        check("rst_fill", fill, 0);

        // Basic block average
        step(1'b1, 10, 1'b1, 1'b0);
        step(1'b1, 20, 1'b1, 1'b0);
        step(1'b1, 30, 1'b1, 1'b0);
        step(1'b1, 40, 1'b1, 1'b0);
        check("t1_valid", mif.m_valid, 1);
        check("t1_data", mif.m_data, 25);
        step(1'b0, 0, 1'b1, 1'b0);
        check("t1_valid_one_cycle", mif.m_valid, 0);
        check("t1_fill", fill, 0);

        // Rounding
        step(1'b1, 1, 1'b1, 1'b0); step(1'b1, 1, 1'b1, 1'b0);
        step(1'b1, 1, 1'b1, 1'b0); step(1'b1, 2, 1'b1, 1'b0);
        check("t2_round_down", mif.m_data, 1);
        step(1'b1, 1, 1'b1, 1'b0); step(1'b1, 2, 1'b1, 1'b0);
        step(1'b1, 2, 1'b1, 1'b0); step(1'b1, 2, 1'b1, 1'b0);
        check("t2_round_up", mif.m_data, 2);
        block(65535, 1'b1);
        check("t2_max", mif.m_data, 65535);
        step(1'b0, 0, 1'b1, 1'b0);

        // Backpressure and overflow
        for (int k = 1; k <= 9; k++) block(k, 1'b0);
        check("t3_fill_full", fill, DEPTH);
        check("t3_overflow", overflow, 1);
        for (int k = 1; k <= 8; k++) begin
            check("t3_drain", mif.m_data, k);
            step(1'b0, 0, 1'b1, 1'b0);
        end
        check("t3_empty", mif.m_valid, 0);

        // Full with simultaneous pop
        step(1'b0, 0, 1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) block(k, 1'b0);
        for (int i = 0; i < D - 1; i++) step(1'b1, 77, 1'b0, 1'b0);
        step(1'b1, 77, 1'b1, 1'b0);
        check("t4_no_overflow", overflow, 0);
        check("t4_fill", fill, DEPTH);
        for (int k = 2; k <= 8; k++) begin
            check("t4_drain", mif.m_data, k);
            step(1'b0, 0, 1'b1, 1'b0);
        end
        check("t4_last", mif.m_data, 77);
        step(1'b0, 0, 1'b1, 1'b0);
        check("t4_empty", mif.m_valid, 0);

        // y_valid gaps
        step(1'b1, 10, 1'b1, 1'b0); step(1'b0, 999, 1'b1, 1'b0);
        step(1'b1, 20, 1'b1, 1'b0); step(1'b0, 999, 1'b1, 1'b0); step(1'b0, 5, 1'b1, 1'b0);
        step(1'b1, 30, 1'b1, 1'b0); step(1'b0, 999, 1'b1, 1'b0);
        check("t5_no_spurious", mif.m_valid, 0);
        step(1'b1, 40, 1'b1, 1'b0);
        check("t5_data", mif.m_data, 25);
        step(1'b0, 0, 1'b1, 1'b0);

        // Reset mid-operation
        for (int k = 1; k <= 3; k++) block(k, 1'b0);
        step(1'b1, 500, 1'b0, 1'b0);
        step(1'b1, 500, 1'b0, 1'b0);
        step(1'b1, 500, 1'b1, 1'b1);
        check("t6_rst_valid", mif.m_valid, 0);
        check("t6_rst_fill", fill, 0);
        block(100, 1'b1);
        check("t6_data", mif.m_data, 100);
        step(1'b0, 0, 1'b1, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            case ($urandom_range(0, 3))
                0:       v = 65535;
                1:       v = $urandom_range(0, 7);
                default: v = $urandom & 16'hFFFF;
            endcase
            step(($urandom_range(0, 3) != 0), v, ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 299) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_out_decim.md
# fir_out_decim

Downstream stage of `fir_filter`: consumes the 16-bit unsigned filter output `y` and decimates it by 2^DEC_LOG2 using block averaging with round-half-up. Each decimated result is pushed into a small first-word-fall-through FIFO. The FIFO drains through a valid/ready handshake toward the next consumer (DMA/UART packer). A sticky flag reports results dropped because the FIFO was full.

## Interface
Parameters:
- `IN_W`, 16, input sample width (matches `fir_filter` `y`).
- `OUT_W`, 16, output word width.
- `DEC_LOG2`, 2, log2 of decimation factor D (D = 4 by default); 0 = bypass.
- `DEPTH`, 8, FIFO depth in entries, power of 2, ≥ 2.

Ports:
- `clk`, input, 1, single clock, rising edge.
- `res`, input, 1, reset; **synchronous, active-high**.
- `y_in`, input, IN_W, unsigned sample from `fir_filter` `y`.
- `y_valid`, input, 1, sample qualifier; tie high for a free-running filter.
- `m_data`, output, OUT_W, FIFO head word.
- `m_valid`, output, 1, FIFO non-empty.
- `m_ready`, input, 1, consumer accepts head word.
- `fill`, output, $clog2(DEPTH)+1, current FIFO occupancy.
- `overflow`, output, 1, sticky; a result was dropped.

## Operation
- Sample counter `cnt` (0..D-1) and accumulator `acc` (IN_W+DEC_LOG2 bits) advance only on cycles with `y_valid` = 1.
- On a valid sample with `cnt` < D-1: `acc <= acc + y_in`, `cnt <= cnt + 1`.
- On a valid sample with `cnt` = D-1 (block complete):
  - `avg = (acc + y_in + R) >> DEC_LOG2`, where R = 2^(DEC_LOG2-1), or 0 when DEC_LOG2 = 0.
  - Sum cannot overflow IN_W+DEC_LOG2 bits; `avg` ≤ 2^IN_W − 1.
  - `acc <= 0`, `cnt <= 0`.
- Width conversion: if OUT_W ≥ IN_W, zero-extend; otherwise saturate to 2^OUT_W − 1.
- Push rule: `avg` is written at the same edge the block completes, if `fill` < DEPTH, or if `fill` = DEPTH and a pop occurs on that edge.
- Otherwise the result is discarded and `overflow <= 1`. `overflow` clears only on reset.
- Pop: occurs when `m_valid` && `m_ready`. The head advances; entries leave in write order.
- Simultaneous push and pop: `fill` is unchanged; both take effect.
- Pointers wrap modulo DEPTH; `fill` distinguishes full from empty.
- `m_data` = head entry when `m_valid` = 1, 0 when the FIFO is empty.
- `m_data` is held stable while `m_valid` && !`m_ready`.

## Timing
- Reset values (after a clock edge with `res` = 1): `acc` = 0, `cnt` = 0, FIFO empty, `m_valid` = 0, `m_data` = 0, `fill` = 0, `overflow` = 0.
- `res` overrides all other inputs, including a pending push or pop.
- Reset mid-block discards the partial sum and all FIFO contents.
- Latency: block-completing sample sampled at edge k → with an empty FIFO, `m_valid` = 1 and `m_data` = avg during the cycle after edge k.
- `fill` updates at the same edges as `m_valid`.
- Throughput: one push per D valid samples and one pop per cycle at most; with D = 1 and `m_ready` = 1, sustains one word per cycle.
- `y_valid` low cycles insert gaps without changing any result.
- `m_valid` never depends combinationally on `m_ready`.

## Test plan
1. D = 4, `m_ready` = 1, `y_in` = 10, 20, 30, 40 on consecutive cycles → `m_valid` high for exactly one cycle, the cycle after the 40 edge; `m_data` = 25; `fill` returns to 0.
2. Rounding: block 1, 1, 1, 2 → `m_data` = 1 (7 >> 2); block 1, 2, 2, 2 → `m_data` = 2 (9 >> 2); block of 65535 ×4 → 65535.
3. Backpressure and overflow:
   - With `m_ready` = 0, feed 9 blocks of constants 1..9 → `fill` = 8, `overflow` = 1.
   - Raise `m_ready` → `m_data` = 1..8 on consecutive cycles, then `m_valid` = 0.
4. Full with simultaneous pop:
   - Fill to 8, then raise `m_ready` on the same edge a block of value 77 completes → no overflow, `fill` stays 8.
   - 77 emerges after the 8 earlier words.
5. `y_valid` gaps: samples 10, 20, 30, 40 with `y_valid` = 0 cycles between them → single output 25, no spurious `m_valid`.
6. Reset mid-operation: 2 samples of 500, plus 3 words queued; pulse `res` for 1 cycle, then 4 samples of 100 → `m_valid` = 0 and `fill` = 0 after the reset edge; the only subsequent output is 100.
